// File: rtl/decode_stage.sv
// RV32/RV64 instruction decode stage: output register plus one skid register, 1-cycle latency.
// in_ready is registered (= !skid_valid); optional M-extension decode under `RV_M_EXT_EN.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_alu_op,
    output logic [15:0]     out_ctrl
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_REG    = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic [15:0]     ctrl;
    } dec_t;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic [3:0]  alu_op;
    logic [1:0]  in1_src;
    logic        alusrc, mem_read, mem_write, reg_write, mem_to_reg;
    logic        is_branch, is_jal, is_jalr, is_csr, is_ecall, is_ebreak;
    logic        is_illegal, is_muldiv;
    dec_t        dec;

    assign opc = in_instr[6:2];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        imm32      = '0;
        alu_op     = ALU_ADD;
        in1_src    = 2'b00;
        alusrc     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_csr     = 1'b0;
        is_ecall   = 1'b0;
        is_ebreak  = 1'b0;
        is_illegal = 1'b0;
        is_muldiv  = 1'b0;
        case (opc)
            OPC_REG: begin
                reg_write = 1'b1;
                alu_op    = alu_from_f3(f3, in_instr[30]);
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    is_illegal = 1'b0;
`ifdef RV_M_EXT_EN
                end else if (f7 == 7'b0000001) begin
                    is_muldiv = 1'b1;
                    alu_op    = ALU_ADD;
`endif
                end else begin
                    is_illegal = 1'b1;
                end
            end
            OPC_IMM: begin
                reg_write = 1'b1;
                alusrc    = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
                // Shift-immediates carry funct7 in the imm field; only bit 30 selects SRA.
                if (f3 == 3'b101) begin
                    alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
                    if (f7 != 7'b0000000 && f7 != 7'b0100000) is_illegal = 1'b1;
                end else begin
                    alu_op = alu_from_f3(f3, 1'b0);
                    if (f3 == 3'b001 && f7 != 7'b0000000) is_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                alusrc     = 1'b1;
                mem_read   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                alusrc    = 1'b1;
                mem_write = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                imm32     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                case (f3[2:1])
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_SUB;
                endcase
            end
            OPC_JAL: begin
                is_jal    = 1'b1;
                reg_write = 1'b1;
                in1_src   = 2'b11;
                alu_op    = ALU_PASS;
                imm32     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                is_jalr   = 1'b1;
                reg_write = 1'b1;
                alusrc    = 1'b1;
                in1_src   = 2'b11;
                alu_op    = ALU_PASS;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_LUI: begin
                reg_write = 1'b1;
                alusrc    = 1'b1;
                in1_src   = 2'b10;
                imm32     = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                alusrc    = 1'b1;
                in1_src   = 2'b01;
                imm32     = {in_instr[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                if (f3 == 3'b000) begin
                    is_ebreak = in_instr[20];
                    is_ecall  = !in_instr[20];
                end else begin
                    is_csr    = 1'b1;
                    reg_write = 1'b1;
                    alusrc    = f3[2];
                end
            end
            default: is_illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) is_illegal = 1'b1;
        if (in_instr[11:7] == 5'd0) reg_write = 1'b0;
        if (ILLEGAL_TRAP != 0 && is_illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            is_branch = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
            is_csr    = 1'b0;
        end
    end

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.imm    = XLEN'($signed(imm32));
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        dec.alu_op = alu_op;
        dec.ctrl   = {1'b0, is_muldiv, is_illegal, is_ebreak, is_ecall, is_csr, is_jalr,
                      is_jal, is_branch, mem_to_reg, reg_write, mem_write, mem_read,
                      in1_src, alusrc};
    end

    dec_t out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
    logic accept;

    assign accept = in_valid && in_ready_q;

    // Skid only fills while the output is stalled, so it is always older than any new input.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_q.pc;
    assign out_imm    = out_q.imm;
    assign out_rd     = out_q.rd;
    assign out_rs1    = out_q.rs1;
    assign out_rs2    = out_q.rs2;
    assign out_funct3 = out_q.funct3;
    assign out_alu_op = out_q.alu_op;
    assign out_ctrl   = out_q.ctrl;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of PC and immediate datapath; legal values 32 and 64.
REQ-002 Parameter ILLEGAL_TRAP, default 1, when 1 an illegal instruction forces all write/memory enables low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous pipeline kill.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-007 in_instr / in_pc  input  32 / XLEN  fetched instruction and its PC.
REQ-008 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-009 out_pc / out_imm  output  XLEN / XLEN  PC passthrough; sign-extended immediate.
REQ-010 out_rd, out_rs1, out_rs2  output  5 each  register indices from the instruction.
REQ-011 out_funct3 / out_alu_op  output  3 / 4  funct3 passthrough; ALU_* encoding from definitions.v.
REQ-012 out_ctrl  output  16  [0] alusrc, [2:1] alu_in1_src, [3] mem_read, [4] mem_write, [5] reg_write, [6] mem_to_reg, [7] is_branch, [8] is_jal, [9] is_jalr, [10] is_csr, [11] is_ecall, [12] is_ebreak, [13] is_illegal, [14] is_muldiv, [15] zero.

Function
REQ-013 Transfer occurs on in_valid && in_ready; latency exactly 1 cycle to out_valid.
REQ-014 Storage: output register plus one skid register; in_ready is registered and equals !skid_valid.
REQ-015 Output stalled (out_valid && !out_ready) with input accepted: decoded word goes to skid register; in_ready drops next cycle.
REQ-016 When output register drains, skid contents move to output next edge; in_ready rises that same edge.
REQ-017 Order preserved; no word dropped or duplicated under any out_ready pattern; full throughput when out_ready held 1.
REQ-018 Output fields stay stable while out_valid && !out_ready.
REQ-019 Decode covers R-type, I-type arithmetic (opcode 00100, incl. SLLI/SRLI/SRAI), load, store, branch, JAL, JALR, LUI, AUIPC, system; alu_in1_src 00 rs1, 01 PC, 10 zero, 11 PC+4.
REQ-020 Immediates: I, S, B, U, J formats sign-extended from bit 31 to XLEN; R-type imm 0.
REQ-021 is_illegal = 1 for instr[1:0] != 2'b11, unlisted opcode, R-type funct7 not 0000000/0100000 (or 0000001 when enabled), SLLI/SRLI funct7 != 0, SRAI funct7 != 0100000.
REQ-022 ILLEGAL_TRAP=1 and is_illegal: reg_write, mem_read, mem_write, is_branch, is_jal, is_jalr, is_csr forced 0.
REQ-023 reg_write forced 0 when rd == x0 for every opcode.
REQ-024 System funct3 000: instr[20]=1 gives is_ebreak, else is_ecall; nonzero funct3 gives is_csr, reg_write, alusrc = funct3[2].
REQ-025 flush: next edge clears output and skid valid, in_ready = 1; input presented in flush cycle is discarded.
REQ-026 flush has priority over simultaneous accept and drain.

Reset
REQ-027 rst_n low: out_valid=0, skid_valid=0, in_ready=1, out_ctrl=0, out_alu_op=ALU_ADD, all other outputs 0, immediately and asynchronously.
REQ-028 Reset mid-stall discards both stored words; first accept after release decodes normally.

Configuration
REQ-029 Macro RV_M_EXT_EN defined: R-type funct7 0000001 decodes as multiply/divide, is_muldiv=1, reg_write=1, out_funct3 selects operation.
REQ-030 RV_M_EXT_EN undefined: funct7 0000001 gives is_illegal=1, is_muldiv tied 0, no M logic synthesised.

Verification
REQ-031 in_instr 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_imm=5, alusrc=1, reg_write=1, out_rd=1, alu_op ALU_ADD.
REQ-032 out_ready=0, accept 0x00500093 then 0x40208133 -> in_ready=0 after second; out_ready=1 -> addi then sub (alu_op ALU_SUB) in order, no loss.
REQ-033 in_instr 0x00000000 -> is_illegal=1, reg_write=0, mem_write=0; 0x00100073 -> is_ebreak=1.
REQ-034 in_instr 0x022081B3 (mul x3,x1,x2) -> with RV_M_EXT_EN is_muldiv=1, reg_write=1; without is_illegal=1, reg_write=0.
REQ-035 Both registers full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flush-cycle word never appears.
REQ-036 rst_n low asynchronously while stalled -> out_valid=0, in_ready=1 before next clock edge.
